// File: rtl/store_align_queue_pkg.sv
// Shared definitions for the store alignment queue.
//   - funct3 encodings for store sizes (SB/SH/SW/SD)
//   - FSM state encodings for the beat sequencer
//   - helpers that decode funct3 into legality and access size
package store_align_queue_pkg;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;
  localparam logic [2:0] FNC_SD = 3'b011;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // A store is legal if it is SB/SH/SW, or SD on a 64-bit datapath.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is64);
    logic ok;
    case (f3)
      FNC_SB, FNC_SH, FNC_SW: ok = 1'b1;
      FNC_SD:                 ok = is64;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Access size in bytes; illegal encodings decode to 0 (empty mask).
  function automatic logic [3:0] store_size(input logic [2:0] f3);
    logic [3:0] sz;
    case (f3)
      FNC_SB:  sz = 4'd1;
      FNC_SH:  sz = 4'd2;
      FNC_SW:  sz = 4'd4;
      FNC_SD:  sz = 4'd8;
      default: sz = 4'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO holding queued store entries.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   push_i, wdata_i   write an entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   rdata_o           head entry (valid when !empty_o)
//   full_o, empty_o   status flags
//   count_o           number of occupied entries
module store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/store_align_queue.sv
// Store path from execute to the data-memory write port.
// Requests are queued, then each head entry is emitted as one lane-aligned
// beat, or two beats when the access crosses a word boundary.
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   req_valid/req_ready                request handshake
//   req_funct3, req_addr, req_data     store size, byte address, right-justified data
//   mem_valid/mem_ready                beat handshake
//   mem_addr, mem_wmask, mem_wdata     word-aligned address, lane mask, lane data
//   err                                one-cycle pulse for an illegal/dropped request
//   count                              occupied queue entries
module store_align_queue
  import store_align_queue_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_funct3,
  input  logic [XLEN-1:0]        req_addr,
  input  logic [XLEN-1:0]        req_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN/8-1:0]      mem_wmask,
  output logic [XLEN-1:0]        mem_wdata,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int SW    = OFFW + 2;           // wide enough for off + size
  localparam int ENTW  = 3 + 2 * XLEN;

  logic              full_s, empty_s, push_s, pop_s;
  logic              req_cross_s, req_ok_s, err_d, err_q;
  logic [ENTW-1:0]   head_s;
  logic [2:0]        hd_funct3_s;
  logic [XLEN-1:0]   hd_addr_s, hd_data_s, base_s;
  logic [SW-1:0]     hd_size_s, hd_off_s;
  logic              hd_cross_s;
  logic [2*BYTES-1:0] mask_base_s, mask2_s;
  logic [2*XLEN-1:0] data2_s;
  state_e            state_q, state_d;

  // A request crossing the word boundary needs two beats.
  assign req_cross_s = ({2'b00, req_addr[OFFW-1:0]} + SW'(store_size(req_funct3))) > SW'(BYTES);
  assign req_ok_s    = funct3_legal(req_funct3, (XLEN == 64)) && (SPLIT_EN || !req_cross_s);
  assign req_ready   = !full_s;
  assign push_s      = req_valid && req_ready && req_ok_s;
  assign err_d       = req_valid && req_ready && !req_ok_s;

  store_fifo #(.WIDTH(ENTW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i ({req_funct3, req_addr, req_data}),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count)
  );

  assign {hd_funct3_s, hd_addr_s, hd_data_s} = head_s;
  assign hd_size_s  = SW'(store_size(hd_funct3_s));
  assign hd_off_s   = {2'b00, hd_addr_s[OFFW-1:0]};
  assign hd_cross_s = (hd_off_s + hd_size_s) > SW'(BYTES);
  assign base_s     = {hd_addr_s[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign mem_valid  = !empty_s;
  assign err        = err_q;

  // Double-width lane mask and data for the head entry
  always_comb begin
    mask_base_s = {2*BYTES{1'b0}};
    for (int i = 0; i < 2*BYTES; i++) begin
      mask_base_s[i] = (i < int'(hd_size_s)) ? 1'b1 : 1'b0;
    end
    mask2_s = mask_base_s << hd_addr_s[OFFW-1:0];
    data2_s = {{XLEN{1'b0}}, hd_data_s} << {hd_addr_s[OFFW-1:0], 3'b000};
  end

  // Beat sequencer: next state and pop decision
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_FIRST: begin
        if (mem_valid && mem_ready) begin
          if (hd_cross_s) begin
            state_d = ST_SECOND;
          end else begin
            pop_s = 1'b1;
          end
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_SECOND: begin
        if (mem_valid && mem_ready) begin
          pop_s   = 1'b1;
          state_d = ST_FIRST;
        end else begin
          state_d = ST_SECOND;
        end
      end
      default: state_d = ST_FIRST;
    endcase
  end

  // Beat outputs; zero whenever no beat is presented
  always_comb begin
    mem_addr  = {XLEN{1'b0}};
    mem_wmask = {BYTES{1'b0}};
    mem_wdata = {XLEN{1'b0}};
    if (mem_valid) begin
      case (state_q)
        ST_FIRST: begin
          mem_addr  = base_s;
          mem_wmask = mask2_s[BYTES-1:0];
          mem_wdata = data2_s[XLEN-1:0];
        end
        ST_SECOND: begin
          // XLEN-bit add wraps the top-of-memory case to address 0
          mem_addr  = base_s + XLEN'(BYTES);
          mem_wmask = mask2_s[2*BYTES-1:BYTES];
          mem_wdata = data2_s[2*XLEN-1:XLEN];
        end
        default: begin
          mem_addr  = {XLEN{1'b0}};
          mem_wmask = {BYTES{1'b0}};
          mem_wdata = {XLEN{1'b0}};
        end
      endcase
    end else begin
      mem_addr  = {XLEN{1'b0}};
      mem_wmask = {BYTES{1'b0}};
      mem_wdata = {XLEN{1'b0}};
    end
  end

  // State and error-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FIRST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule
